// File: rtl/shift_pkg.sv
// Shared constants and types for the multi-cycle log-step shifter.
package shift_pkg;
  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;

  localparam logic [1:0] SHIFT_SLL  = 2'b00;
  localparam logic [1:0] SHIFT_SRA  = 2'b01;
  localparam logic [1:0] SHIFT_ROR  = 2'b10;
  localparam logic [1:0] SHIFT_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;
endpackage

// File: rtl/shift_stage.sv
// One power-of-two shift step (2^idx) for SLL/SRA/ROR; passthrough when disabled or reserved.
module shift_stage
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        mode_i,
  input  logic [1:0]        idx_i,
  input  logic              en_i,
  output logic [DATA_W-1:0] data_o
);
  logic [AMT_W-1:0] sh;

  always_comb begin
    sh     = AMT_W'(1) << idx_i;
    data_o = data_i;
    if (en_i) begin
      unique case (mode_i)
        SHIFT_SLL: data_o = data_i << sh;
        // Each arithmetic step keeps bit 15, so the original sign propagates across stages.
        SHIFT_SRA: data_o = DATA_W'($signed(data_i) >>> sh);
        SHIFT_ROR: data_o = (data_i >> sh) | (data_i << (5'(DATA_W) - {1'b0, sh}));
        default:   data_o = data_i;
      endcase
    end
  end
endmodule

// File: rtl/shift_sequencer.sv
// Four-cycle 16-bit shifter: one shared stage applies steps 1,2,4,8 over successive cycles.
module shift_sequencer
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [AMT_W-1:0]  req_amt,
  input  logic [1:0]        req_mode,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy
);
  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] stage_out;

  shift_stage u_stage (
    .data_i (work_q),
    .mode_i (mode_q),
    .idx_i  (cnt_q),
    .en_i   (amt_q[cnt_q]),
    .data_o (stage_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    amt_d   = amt_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          work_d  = req_data;
          amt_d   = req_amt;
          mode_d  = req_mode;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = stage_out;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by rst_n so nothing is accepted while reset is held.
  assign req_ready  = rst_n && (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign resp_data  = work_q;
  assign resp_err   = resp_valid && (mode_q == SHIFT_RSVD);
endmodule
